// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter sequencer and its seek helper.
package counter_sequencer_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    OpLoad = 2'd0,
    OpUp   = 2'd1,
    OpDown = 2'd2,
    OpSeek = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StSettle,
    StResp
  } state_e;

  typedef enum logic {
    StatusOk      = 1'b0,
    StatusAborted = 1'b1
  } status_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command/response handshake bundle between the host and the counter sequencer.
interface counter_sequencer_if
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             abort;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_count;
  logic [WIDTH-1:0] rsp_steps;
  logic             rsp_status;

  modport master (
    output cmd_valid, cmd_op, cmd_data, abort, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_count, rsp_steps, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, abort, rsp_ready,
    output cmd_ready, rsp_valid, rsp_count, rsp_steps, rsp_status
  );

endinterface

// File: rtl/counter_seek_calc.sv
// Shortest-path direction and step count from current to target on a modular counter.
module counter_seek_calc
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] current,
  output logic             dir,
  output logic [WIDTH-1:0] steps
);

  localparam logic [WIDTH-1:0] Half = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [WIDTH-1:0] diff;

  always_comb begin
    diff = target - current;
    // Exactly half-way round counts as going up.
    if (diff <= Half) begin
      dir   = 1'b1;
      steps = diff;
    end else begin
      dir   = 1'b0;
      steps = WIDTH'(0) - diff;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller for an external up/down counter: issues load or an exact
// enable pulse train, then reports the settled count, steps issued and status.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_sequencer_if.slave bus,
  output logic             cnt_load,
  output logic             cnt_en,
  output logic             cnt_m,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             up_q, up_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  status_e          status_q, status_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic             seek_dir;
  logic [WIDTH-1:0] seek_steps;

  counter_seek_calc #(
    .WIDTH (WIDTH)
  ) u_seek_calc (
    .target  (bus.cmd_data),
    .current (cnt_count),
    .dir     (seek_dir),
    .steps   (seek_steps)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    n_d      = n_q;
    up_d     = up_q;
    steps_d  = steps_q;
    status_d = status_q;
    count_d  = count_q;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          data_d   = bus.cmd_data;
          steps_d  = '0;
          status_d = StatusOk;
          case (bus.cmd_op)
            OpLoad: begin
              n_d  = '0;
              up_d = 1'b0;
            end
            OpUp: begin
              n_d  = bus.cmd_data;
              up_d = 1'b1;
            end
            OpDown: begin
              n_d  = bus.cmd_data;
              up_d = 1'b0;
            end
            default: begin
              n_d  = seek_steps;
              up_d = seek_dir;
            end
          endcase
          if (bus.cmd_op == OpLoad) begin
            state_d = StLoad;
          end else if (n_d == '0) begin
            state_d = StSettle;
          end else begin
            state_d = StRun;
          end
        end
      end

      StLoad: state_d = StSettle;

      StRun: begin
        // The enable cycle ending at this edge always counts, even when aborting.
        steps_d = steps_q + WIDTH'(1);
        if (bus.abort) begin
          status_d = StatusAborted;
          state_d  = StSettle;
        end else if (steps_d == n_q) begin
          state_d = StSettle;
        end
      end

      StSettle: begin
        count_d = cnt_count;
        state_d = StResp;
      end

      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      data_q   <= '0;
      n_q      <= '0;
      up_q     <= 1'b0;
      steps_q  <= '0;
      status_q <= StatusOk;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      n_q      <= n_d;
      up_q     <= up_d;
      steps_q  <= steps_d;
      status_q <= status_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    bus.cmd_ready  = (state_q == StIdle);
    cnt_load       = (state_q == StLoad);
    cnt_en         = (state_q == StRun);
    cnt_m          = cnt_en & up_q;
    cnt_data       = cnt_load ? data_q : '0;
    bus.rsp_valid  = (state_q == StResp);
    bus.rsp_count  = count_q;
    bus.rsp_steps  = steps_q;
    bus.rsp_status = status_q;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer driving a behavioural 8-bit up/down counter.
module tb_counter_sequencer;
  import counter_sequencer_pkg::*;

  localparam int unsigned W = 8;

  typedef struct {
    logic [7:0] count;
    logic [7:0] steps;
    logic       status;
    int         lat;
    int         en;
    int         loads;
    logic       dir;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cnt_load, cnt_en, cnt_m;
  logic [W-1:0] cnt_data;
  logic [W-1:0] cnt_count = 8'h00;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   model = 0;
  exp_t sb_q[$];

  counter_sequencer_if #(.WIDTH(W)) bus ();

  counter_sequencer #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cnt_load  (cnt_load),
    .cnt_en    (cnt_en),
    .cnt_m     (cnt_m),
    .cnt_data  (cnt_data),
    .cnt_count (cnt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The counter under control; deliberately not reset by rst_n.
  always @(posedge clk) begin
    if (cnt_load) cnt_count <= cnt_data;
    else if (cnt_en) cnt_count <= cnt_m ? cnt_count + 8'd1 : cnt_count - 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t        cur;
  bit          in_flight = 1'b0;
  int          acc_cyc, en_seen, load_seen, lat_seen;
  bit          m_bad, proto_bad;
  logic [16:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (in_flight) begin
        cur       = sb_q.pop_front();
        in_flight = 1'b0;
      end
    end else begin
      if (in_flight) begin
        if (cnt_en) begin
          en_seen++;
          if (cnt_m !== cur.dir) m_bad = 1'b1;
        end
        if (cnt_load) begin
          load_seen++;
          if (cnt_data !== cur.count) proto_bad = 1'b1;
        end else if (cnt_data !== 8'h00) begin
          proto_bad = 1'b1;
        end
        if (bus.cmd_ready) proto_bad = 1'b1;
        if (bus.rsp_valid) begin
          if (lat_seen < 0) begin
            lat_seen = cyc - acc_cyc;
            held     = {bus.rsp_count, bus.rsp_steps, bus.rsp_status};
          end else if ({bus.rsp_count, bus.rsp_steps, bus.rsp_status} !== held) begin
            proto_bad = 1'b1;
          end
          if (bus.rsp_ready) begin
            check("rsp_count", bus.rsp_count, cur.count);
            check("rsp_steps", bus.rsp_steps, cur.steps);
            check("rsp_status", bus.rsp_status, cur.status);
            check("latency", lat_seen, cur.lat);
            check("en_cycles", en_seen, cur.en);
            check("load_pulses", load_seen, cur.loads);
            check("m_stable", m_bad, 0);
            check("protocol", proto_bad, 0);
            cur       = sb_q.pop_front();
            in_flight = 1'b0;
          end
        end
      end else if (bus.rsp_valid) begin
        check("spurious_rsp", bus.rsp_valid, 0);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (sb_q.size() == 0) begin
          check("accept_without_cmd", sb_q.size(), 1);
        end else begin
          cur       = sb_q[0];
          in_flight = 1'b1;
          acc_cyc   = cyc;
          en_seen   = 0;
          load_seen = 0;
          lat_seen  = -1;
          m_bad     = 1'b0;
          proto_bad = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input op_e op, input logic [7:0] data, input int abort_after,
                       input int stall, input bit abort_on_accept);
    exp_t e;
    int   n, diff, steps, k, t;
    bit   up, aborted;
    n = 0;
    up = 1'b0;
    case (op)
      OpUp:   begin n = data; up = 1'b1; end
      OpDown: begin n = data; up = 1'b0; end
      OpSeek: begin
        diff = (int'(data) - model) & 255;
        if (diff <= 128) begin n = diff; up = 1'b1; end
        else begin n = 256 - diff; up = 1'b0; end
      end
      default: ;
    endcase
    aborted = (op != OpLoad) && abort_after >= 1 && abort_after < n;
    steps   = aborted ? abort_after : n;
    if (op == OpLoad) begin
      model   = data;
      e.lat   = 3;
      e.loads = 1;
    end else begin
      model   = up ? (model + steps) & 255 : (model - steps) & 255;
      e.lat   = steps + 2;
      e.loads = 0;
    end
    e.count  = 8'(model);
    e.steps  = 8'(steps);
    e.status = aborted;
    e.en     = steps;
    e.dir    = up;
    sb_q.push_back(e);

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    if (abort_on_accept) bus.abort = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    if (t == 50) check("accept_timeout", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;

    if (aborted) begin
      k = 0;
      for (t = 0; t < 600; t++) begin
        @(negedge clk);
        if (cnt_en) k++;
        if (k == abort_after) break;
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
    end

    for (t = 0; t < 600; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    if (t == 600) check("rsp_timeout", bus.rsp_valid, 1);
    repeat (stall) @(posedge clk);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t       e;
    op_e        op;
    logic [7:0] d;
    int         ab, k;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OpLoad;
    bus.cmd_data  = '0;
    bus.abort     = 1'b0;
    bus.rsp_ready = 1'b0;

    @(posedge clk);
    #1;
    check("reset_outputs", {cnt_en, cnt_load, cnt_m, cnt_data, bus.rsp_valid, bus.rsp_count,
                            bus.rsp_steps, bus.rsp_status, bus.cmd_ready}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of UP 50 after 10 enable cycles.
    e.count = 8'd50; e.steps = 8'd50; e.status = 1'b0;
    e.lat = 52; e.en = 50; e.loads = 0; e.dir = 1'b1;
    sb_q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OpUp;
    bus.cmd_data  = 8'd50;
    @(negedge clk);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    k = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (cnt_en) k++;
      if (k == 10) break;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {cnt_en, cnt_load, cnt_m, cnt_data, bus.rsp_valid,
                                  bus.rsp_count, bus.rsp_steps, bus.rsp_status,
                                  bus.cmd_ready}, 32'h1);
    model = 10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("counter_holds", cnt_count, 8'd10);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", bus.cmd_ready, 1);

    issue(OpLoad, 8'h10, -1, 0, 1'b0);
    issue(OpLoad, 8'hFE, -1, 0, 1'b0);
    issue(OpUp, 8'd5, -1, 1, 1'b0);
    issue(OpLoad, 8'hFB, -1, 0, 1'b0);
    issue(OpSeek, 8'h05, -1, 0, 1'b0);
    issue(OpLoad, 8'h80, -1, 0, 1'b0);
    issue(OpSeek, 8'h00, -1, 0, 1'b0);
    issue(OpLoad, 8'h10, -1, 0, 1'b0);
    issue(OpSeek, 8'hF0, -1, 2, 1'b0);
    issue(OpSeek, 8'hF0, -1, 0, 1'b0);
    issue(OpLoad, 8'h30, -1, 0, 1'b0);
    issue(OpDown, 8'd20, 7, 0, 1'b0);
    issue(OpUp, 8'd3, -1, 0, 1'b1);
    issue(OpUp, 8'd0, -1, 10, 1'b0);
    issue(OpLoad, 8'h55, -1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = op_e'($urandom_range(0, 3));
      if (op == OpUp || op == OpDown) d = 8'($urandom_range(0, 24));
      else d = 8'($urandom_range(0, 255));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
      issue(op, d, ab, int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Command-driven controller that owns the control inputs of one 8-bit up/down counter (load, enable, mode, data_in) and observes its count output. Accepts LOAD / UP-N / DOWN-N / SEEK commands over a valid/ready handshake and issues the exact enable pulse train. Returns the settled count, steps issued and status over a valid/ready response channel. Sits between the test/host logic and the counter instance in the top level.

Parameters:
WIDTH, 8, counter and data width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  high only in IDLE.
cmd_op  in  2  0=LOAD, 1=UP, 2=DOWN, 3=SEEK.
cmd_data  in  WIDTH  LOAD value / step count N / SEEK target.
abort  in  1  stop the enable train early (RUN only).
cnt_load  out  1  to counter load.
cnt_en  out  1  to counter en.
cnt_m  out  1  to counter m (1=up, 0=down).
cnt_data  out  WIDTH  to counter data_in.
cnt_count  in  WIDTH  from counter count.
rsp_valid  out  1  response present.
rsp_ready  in  1  response accepted.
rsp_count  out  WIDTH  counter value after the operation.
rsp_steps  out  WIDTH  number of cnt_en cycles issued.
rsp_status  out  1  0=OK, 1=ABORTED.

Behaviour:
- Reset: state IDLE. All outputs 0 except cmd_ready=1. Internal regs 0. Reset mid-operation abandons the command and leaves the counter where it stopped.
- Counter contract: load has priority over en. When en=1, m=1 increments and m=0 decrements, both mod 2^WIDTH. count updates on the clock edge.
- States: IDLE, LOAD, RUN, SETTLE, RESP. All counter-side outputs decode from registered state; there is no combinational input-to-output path.
- IDLE: accept on cmd_valid && cmd_ready. Latch op and data; clear the step counter.
- Accept LOAD -> LOAD: cnt_load=1 and cnt_data=latched value for exactly 1 cycle -> SETTLE.
- Accept UP/DOWN -> N=cmd_data, cnt_m=1/0.
- Accept SEEK -> at the accept cycle, diff=(target - cnt_count) mod 2^WIDTH:
  - diff=0: N=0.
  - diff<=2^(WIDTH-1): up, N=diff. The tie at 128 goes up.
  - otherwise: down, N=2^WIDTH - diff.
- N=0 -> SETTLE directly; no cnt_en pulse.
- N>0 -> RUN:
  - cnt_en=1 for exactly N consecutive cycles; cnt_m stable throughout.
  - rsp_steps increments per en cycle.
  - Exit to SETTLE when steps==N.
- abort in RUN, sampled at a clock edge: en cycles stop after that edge, state -> SETTLE, status ABORTED.
- abort is ignored outside RUN, including in the accept cycle.
- SETTLE: 1 cycle, all counter controls 0. rsp_count captures cnt_count at the end of the cycle -> RESP.
- RESP: rsp_valid=1; rsp_count/steps/status held stable until rsp_ready. On handshake -> IDLE, rsp_valid=0 next cycle, cmd_ready=1.
- Latency, accept to rsp_valid:
  - LOAD: 3 cycles.
  - UP/DOWN/SEEK: N+2 cycles.
  - N=0: 2 cycles.
- Back-to-back: next command is accepted at the earliest the cycle after the response handshake.
- Wrap-around is counter-native; the sequencer never saturates.
- cnt_data is driven only in LOAD and is 0 otherwise.

Decomposition:
- Package counter_sequencer_pkg: op_e (LOAD/UP/DOWN/SEEK), state_e, status_e, WIDTH default constant.
- One natural sub-module: counter_seek_calc (combinational). Inputs: target, current. Outputs: dir, steps.

Test Plan:
1. Reset asserted mid-RUN (UP 50, after 10 en cycles) -> all outputs 0 asynchronously, cmd_ready=1 after release, counter holds its value.
2. LOAD 0x10 -> cnt_load high 1 cycle with cnt_data=0x10. Response count=0x10, steps=0, OK, 3 cycles after accept.
3. LOAD 0xFE, then UP 5 -> cnt_en high 5 cycles with m=1. Response count=0x03, steps=5 (wrap).
4. SEEK cases, each with exact en cycle count checked:
   - from 0xFB to 0x05: up 10, count=0x05.
   - from 0x80 to 0x00: up 128.
   - from 0x10 to 0xF0: down 32.
   - SEEK to current value: no en, steps=0.
5. LOAD 0x30, DOWN 20, abort after the 7th en cycle -> exactly 7 en cycles. Response count=0x29, steps=7, ABORTED.
6. UP 0 with rsp_ready low for 10 cycles -> no en pulse. Response stable throughout, cmd_ready=0 until handshake, then new command accepted.
